// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the DMEM port arbiter.
//   ls_size_t   - load/store access size (byte, half, word)
//   dmem_req_t  - one DMEM request beat {we, addr, wdata, size}
//   DMEM_LAT    - default DMEM read latency in cycles
//   idx_w()     - width of an index into n items, never below 1
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2
  } ls_size_t;

  localparam int LS_SIZE_W = $bits(ls_size_t);
  localparam int DMEM_LAT  = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    ls_size_t    size;
  } dmem_req_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side bus of the DMEM arbiter.
//   req_valid_i/req_ready_o  per-requester valid/ready handshake
//   req_we_i/addr/wdata/size per-requester request fields, 32-bit lanes packed by index
//   rsp_valid_o              one-hot response valid, routed to the issuing requester
//   rsp_rdata_o              DMEM read data broadcast to all requesters
// modport master: requester side; modport slave: arbiter side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]           req_valid_i;
  logic [NREQ-1:0]           req_ready_o;
  logic [NREQ-1:0]           req_we_i;
  logic [NREQ*32-1:0]        req_addr_i;
  logic [NREQ*32-1:0]        req_wdata_i;
  logic [NREQ*LS_SIZE_W-1:0] req_size_i;
  logic [NREQ-1:0]           rsp_valid_o;
  logic [31:0]               rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// dmem_arbiter_rr: round-robin arbiter with the rotating pointer held inside.
//   clk, rst_n   clock, synchronous active-low reset (pointer returns to 0)
//   elig_i       eligible requesters
//   gnt_o        one-hot grant (combinational)
//   gnt_idx_o    index of the granted requester
//   gnt_any_o    a grant was issued this cycle
// The scan starts at rr_ptr and wraps; after a grant to g the pointer moves
// to g+1 so the winner has lowest priority next time.
module dmem_arbiter_rr
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] elig_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            gnt_any_o
);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin : scan
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any_o && elig_i[idx]) begin
        gnt_any_o  = 1'b1;
        gnt_idx_o  = IW'(idx);
        gnt_o[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any_o) begin
      rr_ptr_d = (gnt_idx_o == IW'(NREQ - 1)) ? '0 : gnt_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency DMEM port among NREQ requesters.
//   clk, rst_n      clock, synchronous active-low reset
//   flush_i         flush pulse; kills traffic of requesters set in FLUSH_MASK
//   bus (slave)     requester handshake, request fields and routed responses
//   dmem_*_o        DMEM request, driven combinationally from the granted requester
//   dmem_rvalid_i   DMEM response valid, LAT cycles after dmem_en_o
//   dmem_rdata_i    DMEM read data
//   spurious_o      response arrived with no live in-flight entry
// A LAT-deep tag pipeline remembers who owns each in-flight access so the
// response can be routed back. Stores ride the pipeline too; their response
// is the store acknowledge.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int              NREQ       = 2,
  parameter int              LAT        = DMEM_LAT,
  parameter logic [NREQ-1:0] FLUSH_MASK = NREQ'(2'b01)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  dmem_arbiter_if.slave  bus,
  output logic           dmem_en_o,
  output logic           dmem_we_o,
  output logic [31:0]    dmem_addr_o,
  output logic [31:0]    dmem_wdata_o,
  output ls_size_t       dmem_size_o,
  input  logic           dmem_rvalid_i,
  input  logic [31:0]    dmem_rdata_i,
  output logic           spurious_o
);

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0] elig, gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  dmem_req_t       dreq;

  logic [LAT-1:0]         st_v_q;
  logic [LAT-1:0][IW-1:0] st_own_q;
  logic [IW-1:0]          tail_own;

  // Gating eligibility with rst_n forces every grant-derived output low in reset.
  assign elig = bus.req_valid_i & ~(FLUSH_MASK & {NREQ{flush_i}}) & {NREQ{rst_n}};

  dmem_arbiter_rr #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .elig_i    (elig),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign bus.req_ready_o = gnt;

  always_comb begin
    dreq = '{we: 1'b0, addr: '0, wdata: '0, size: LS_W};
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        dreq.we    = bus.req_we_i[i];
        dreq.addr  = bus.req_addr_i[32*i +: 32];
        dreq.wdata = bus.req_wdata_i[32*i +: 32];
        dreq.size  = ls_size_t'(bus.req_size_i[LS_SIZE_W*i +: LS_SIZE_W]);
      end
    end
  end

  assign dmem_en_o    = gnt_any;
  assign dmem_we_o    = dreq.we;
  assign dmem_addr_o  = dreq.addr;
  assign dmem_wdata_o = dreq.wdata;
  assign dmem_size_o  = dreq.size;

  // Stage 0 never needs a flush kill: a masked requester cannot win while
  // flush_i is high. Older stages drop masked owners as they shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_v_q   <= '0;
      st_own_q <= '0;
    end else begin
      st_v_q[0]   <= gnt_any;
      st_own_q[0] <= gnt_idx;
      for (int k = 1; k < LAT; k++) begin
        st_v_q[k]   <= st_v_q[k-1] && !(flush_i && FLUSH_MASK[st_own_q[k-1]]);
        st_own_q[k] <= st_own_q[k-1];
      end
    end
  end

  assign tail_own = st_own_q[LAT-1];

  always_comb begin
    bus.rsp_valid_o = '0;
    if (rst_n && dmem_rvalid_i && st_v_q[LAT-1] && !(flush_i && FLUSH_MASK[tail_own])) begin
      bus.rsp_valid_o[tail_own] = 1'b1;
    end
  end

  assign bus.rsp_rdata_o = dmem_rdata_i;
  assign spurious_o      = rst_n && dmem_rvalid_i && !st_v_q[LAT-1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter (NREQ=2, LAT=2, FLUSH_MASK=01).
// A vector table covers grant/mux/round-robin behaviour cycle by cycle; short
// hand-written sequences cover the response pipeline, flush, store ack,
// spurious responses and reset in flight.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam logic [31:0] A0 = 32'h1000_0100;
  localparam logic [31:0] A1 = 32'h2000_0040;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dmem_en, dmem_we, dmem_rvalid, spurious;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  ls_size_t    dmem_size;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.NREQ(2)) bus ();

  dmem_arbiter #(.NREQ(2), .LAT(2), .FLUSH_MASK(2'b01)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .bus           (bus),
    .dmem_en_o     (dmem_en),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_size_o   (dmem_size),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .spurious_o    (spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic        flush;
    logic [1:0]  ready;
    logic        en;
    logic        dwe;
    logic [31:0] addr;
    logic [31:0] wdata;
    ls_size_t    size;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 2'b00;
    bus.req_we_i    = 2'b00;
    flush           = 1'b0;
    dmem_rvalid     = 1'b0;
  endtask

  // Holds reset for one edge with traffic present; everything must stay low.
  task automatic do_reset(input string tag);
    rst_n           = 1'b0;
    bus.req_valid_i = 2'b11;
    dmem_rvalid     = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_ready"},    32'(bus.req_ready_o), 32'h0);
    chk({tag, ".rst_en"},       32'(dmem_en),         32'h0);
    chk({tag, ".rst_rsp"},      32'(bus.rsp_valid_o), 32'h0);
    chk({tag, ".rst_spurious"}, 32'(spurious),        32'h0);
    next();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, LS_W};
    vecs[1] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, A0,    W0,    LS_B};
    vecs[2] = '{2'b11, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, A1,    W1,    LS_H};
    vecs[3] = '{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, A0,    W0,    LS_B};
    vecs[4] = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0,    W0,    LS_B};
    vecs[5] = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, A1,    W1,    LS_H};
    vecs[6] = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, A1,    W1,    LS_H};
    vecs[7] = '{2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, LS_W};
    vecs[8] = '{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, A0,    W0,    LS_B};
    vecs[9] = '{2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1, A1,    W1,    LS_H};

    rst_n            = 1'b0;
    bus.req_addr_i   = {A1, A0};
    bus.req_wdata_i  = {W1, W0};
    bus.req_size_i   = {LS_H, LS_B};
    dmem_rdata       = 32'h0;
    idle_inputs();
    next();

    // ---- table: grant, mux and round-robin pointer movement
    do_reset("tab");
    foreach (vecs[i]) begin
      bus.req_valid_i = vecs[i].valid;
      bus.req_we_i    = vecs[i].we;
      flush           = vecs[i].flush;
      @(negedge clk);
      chk($sformatf("v%0d.ready", i), 32'(bus.req_ready_o), 32'(vecs[i].ready));
      chk($sformatf("v%0d.en", i),    32'(dmem_en),         32'(vecs[i].en));
      chk($sformatf("v%0d.we", i),    32'(dmem_we),         32'(vecs[i].dwe));
      chk($sformatf("v%0d.addr", i),  dmem_addr,            vecs[i].addr);
      chk($sformatf("v%0d.wdata", i), dmem_wdata,           vecs[i].wdata);
      chk($sformatf("v%0d.size", i),  32'(dmem_size),       32'(vecs[i].size));
      next();
    end
    idle_inputs();

    // ---- single LSU load
    do_reset("load");
    bus.req_addr_i  = {A1, 32'h0000_0100};
    bus.req_valid_i = 2'b01;
    @(negedge clk);
    chk("load.en",   32'(dmem_en), 32'h1);
    chk("load.addr", dmem_addr,    32'h100);
    next();
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    chk("load.rsp_t1", 32'(bus.rsp_valid_o), 32'h0);
    next();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_0001;
    @(negedge clk);
    chk("load.rsp_t2", 32'(bus.rsp_valid_o), 32'h1);
    chk("load.rdata",  bus.rsp_rdata_o,      32'hCAFE_0001);
    chk("load.spur",   32'(spurious),        32'h0);
    next();
    idle_inputs();
    bus.req_addr_i = {A1, A0};

    // ---- contention: alternating grants, responses two cycles behind
    do_reset("cont");
    for (int t = 0; t < 8; t++) begin
      bus.req_valid_i = (t < 6) ? 2'b11 : 2'b00;
      dmem_rvalid     = (t >= 2);
      dmem_rdata      = 32'h5000_0000 + 32'(t);
      @(negedge clk);
      if (t < 6)
        chk($sformatf("cont.gnt%0d", t), 32'(bus.req_ready_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      if (t >= 2)
        chk($sformatf("cont.rsp%0d", t), 32'(bus.rsp_valid_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      else
        chk($sformatf("cont.rsp%0d", t), 32'(bus.rsp_valid_o), 32'h0);
      next();
    end
    idle_inputs();

    // ---- flush with mixed in-flight traffic
    do_reset("fl");
    bus.req_valid_i = 2'b01;
    @(negedge clk);
    chk("fl.gnt_t0", 32'(bus.req_ready_o), 32'h1);
    next();
    bus.req_valid_i = 2'b11;
    flush           = 1'b1;
    @(negedge clk);
    chk("fl.gnt_t1", 32'(bus.req_ready_o), 32'h2);
    next();
    idle_inputs();
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("fl.rsp_t2",  32'(bus.rsp_valid_o), 32'h0);
    chk("fl.spur_t2", 32'(spurious),        32'h1);
    next();
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("fl.rsp_t3", 32'(bus.rsp_valid_o), 32'h2);
    next();
    idle_inputs();

    // ---- flush in the response cycle: unmasked delivered, masked dropped
    do_reset("flr");
    bus.req_valid_i = 2'b10;
    next();
    bus.req_valid_i = 2'b01;
    next();
    bus.req_valid_i = 2'b00;
    flush           = 1'b1;
    dmem_rvalid     = 1'b1;
    @(negedge clk);
    chk("flr.rsp_owner1", 32'(bus.rsp_valid_o), 32'h2);
    next();
    @(negedge clk);
    chk("flr.rsp_owner0", 32'(bus.rsp_valid_o), 32'h0);
    next();
    idle_inputs();

    // ---- store ack
    do_reset("st");
    bus.req_addr_i  = {32'h0000_0040, A0};
    bus.req_wdata_i = {32'hDEAD_BEEF, W0};
    bus.req_valid_i = 2'b10;
    bus.req_we_i    = 2'b10;
    @(negedge clk);
    chk("st.ready", 32'(bus.req_ready_o), 32'h2);
    chk("st.we",    32'(dmem_we),         32'h1);
    chk("st.addr",  dmem_addr,            32'h40);
    chk("st.wdata", dmem_wdata,           32'hDEAD_BEEF);
    next();
    idle_inputs();
    next();
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("st.ack", 32'(bus.rsp_valid_o), 32'h2);
    next();
    idle_inputs();
    bus.req_addr_i  = {A1, A0};
    bus.req_wdata_i = {W1, W0};

    // ---- spurious response on an empty pipeline
    do_reset("sp");
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("sp.pulse", 32'(spurious),        32'h1);
    chk("sp.rsp",   32'(bus.rsp_valid_o), 32'h0);
    next();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("sp.clear", 32'(spurious), 32'h0);
    next();

    // ---- reset while a grant is in flight
    do_reset("rf");
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("rf.gnt_t0", 32'(bus.req_ready_o), 32'h1);
    next();
    rst_n           = 1'b0;
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    chk("rf.rsp_t1", 32'(bus.rsp_valid_o), 32'h0);
    next();
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("rf.rsp_t2",  32'(bus.rsp_valid_o), 32'h0);
    chk("rf.spur_t2", 32'(spurious),        32'h1);
    next();
    dmem_rvalid     = 1'b0;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("rf.ptr_zero", 32'(bus.req_ready_o), 32'h1);
    chk("rf.rsp_t3",   32'(bus.rsp_valid_o), 32'h0);
    next();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single BRAM-style DMEM port (fixed LAT-cycle read latency, one request per cycle) between NREQ requesters: the core LSU plus secondary agents such as a debug or loader port.
- Round-robin grant with a per-requester valid/ready handshake.
- Tracks in-flight grants in a LAT-deep tag pipeline and routes each dmem_rvalid_i back to the requester that issued it.
- flush_i kills only in-flight traffic from flushable requesters (FLUSH_MASK), so stale core responses never reach a post-flush LSU.

Parameters:
NREQ, 2, number of requesters (2..8); index 0 is the core LSU.
LAT, 2, DMEM response latency in cycles, from dmem_en_o to dmem_rvalid_i (1..4).
FLUSH_MASK, 'b01, NREQ-bit mask; bit i=1 means requester i is killed by flush_i.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  pipeline flush pulse
req_valid_i  in  NREQ  request valid per requester
req_ready_o  out  NREQ  grant; transfer when valid&&ready
req_we_i  in  NREQ  write enable per requester
req_addr_i  in  NREQ*32  byte address, requester i at [32i+31:32i]
req_wdata_i  in  NREQ*32  store data, same packing
req_size_i  in  NREQ*$bits(ls_size_t)  access size per requester
dmem_en_o  out  1  DMEM request strobe
dmem_we_o  out  1  DMEM write enable
dmem_addr_o  out  32  DMEM address
dmem_wdata_o  out  32  DMEM write data
dmem_size_o  out  ls_size_t  DMEM access size
dmem_rvalid_i  in  1  DMEM response valid, LAT cycles after dmem_en_o
dmem_rdata_i  in  32  DMEM read data
rsp_valid_o  out  NREQ  one-hot response valid, routed by owner
rsp_rdata_o  out  32  dmem_rdata_i broadcast to all requesters
spurious_o  out  1  pulse: dmem_rvalid_i with no live in-flight entry

Behaviour:
- Reset (rst_n=0 at posedge):
  - rr_ptr <= 0; all tag-pipeline stages invalid.
  - req_ready_o, dmem_en_o, rsp_valid_o and spurious_o are all 0 while rst_n=0; the combinational outputs are gated by rst_n.
- Eligibility: requester i is eligible when req_valid_i[i] && !(flush_i && FLUSH_MASK[i]).
- Grant (combinational):
  - Pick the first eligible requester scanning from rr_ptr upward, wrapping modulo NREQ.
  - At most one req_ready_o bit is high.
  - A requester whose ready is low must hold its request stable. Requesters without backpressure (the LSU) must keep valid asserted until ready is seen.
- rr_ptr update: on a grant to index g, rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
- DMEM drive:
  - dmem_en_o = any grant.
  - we/addr/wdata/size are muxed from the granted index. They are all-zero when there is no grant; size is LS_W.
  - Zero-cycle request latency (combinational path from req to dmem).
- Tag pipeline:
  - Stage 0 captures {v=grant, owner=g}. Stages 1..LAT-1 shift each cycle.
  - Stage LAT-1 pairs with dmem_rvalid_i in the same cycle.
  - Writes also occupy the pipeline; their response pulse is the store ack.
- Response:
  - rsp_valid_o[owner] = dmem_rvalid_i && st[LAT-1].v && !(flush_i && FLUSH_MASK[owner]).
  - spurious_o = dmem_rvalid_i && !st[LAT-1].v.
  - No rsp_valid_o is produced for a missing rvalid; that entry is silently dropped.
- Flush:
  - On the flush cycle, every pipeline stage whose owner is in FLUSH_MASK is invalidated at the clock edge. Stages for unmasked owners keep shifting normally.
  - Masked requesters get no grant in the flush cycle.
  - rr_ptr still advances on any unmasked grant made that cycle.
- Simultaneous events:
  - Grant and response in the same cycle are independent, so full throughput is one request per cycle.
  - Flush together with a response for an unmasked owner: that response is delivered.
- Reset mid-operation: all in-flight entries are discarded. A late dmem_rvalid_i after reset is reported as spurious_o only, with no rsp_valid_o.
- Widths: owner index is $clog2(NREQ) bits, minimum 1.

Decomposition:
- ooop_types gains dmem_req_t {we, addr, wdata, size} and the DMEM_LAT constant (=2).
- Shared functions needed: none beyond ls_size_t.
- Sub-module rr_arbiter (NREQ, eligible vector in, one-hot grant out, rr_ptr state inside) is natural and reusable for CDB arbitration.

Test Plan:
- Single LSU load: req0 addr=0x100, no other traffic.
  - Required: dmem_en_o at t0 with addr 0x100.
  - Required: rsp_valid_o=01 at t0+2, rsp_rdata_o equal to dmem_rdata_i.
- Contention: both requesters valid every cycle for 6 cycles, rr_ptr=0.
  - Required: grants alternate 0,1,0,1,0,1.
  - Required: responses alternate owners with a 2-cycle offset and no bubbles.
- Flush with mixed in-flight traffic: req0 granted t0, req1 granted t1, flush_i at t1.
  - Required: t2 response is suppressed (owner 0).
  - Required: t3 rsp_valid_o=10 is delivered.
  - Required: req0 is not granted at t1.
- Store ack: req1 we=1 addr=0x40 wdata=0xDEADBEEF.
  - Required: dmem_we_o=1 and dmem_wdata_o=0xDEADBEEF at t0.
  - Required: rsp_valid_o=10 at t0+2.
- Spurious response: dmem_rvalid_i forced with the pipeline empty.
  - Required: spurious_o=1 for one cycle, rsp_valid_o=00.
- Reset mid-flight: grant at t0, rst_n=0 at t1, rvalid at t2.
  - Required: no rsp_valid_o at any point; rr_ptr is 0 after reset.
